// File: rtl/pe_2in1out_join.sv
// Join stage: two token FIFOs, pop both heads together, pipelined wrapping sum.
// Fire-to-output latency LATENCY cycles; a stalled output freezes the whole pipeline.

module pe_2in1out_join_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push_vld,
  input  logic [W-1:0]  i_push_dat,
  output logic          o_push_rdy,
  input  logic          i_pop,
  output logic [W-1:0]  o_head_dat,
  output logic [CW-1:0] o_count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;

  // Readiness follows occupancy only, so a pop never frees a slot in the same cycle.
  assign o_push_rdy = (r_count != FULL_CNT);
  assign w_push     = i_push_vld && o_push_rdy;
  assign o_head_dat = r_mem[r_rd_ptr];
  assign o_count    = r_count;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PW'(1);
      if (i_pop)  r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(i_pop);
    end
  end
endmodule

module pe_2in1out_join #(
  parameter int WIDTH   = 16,
  parameter int LATENCY = 15,
  parameter int DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             data_in_1,
  input  logic                         valid_in_1,
  output logic                         ready_in_1,
  input  logic [WIDTH-1:0]             data_in_2,
  input  logic                         valid_in_2,
  output logic                         ready_in_2,
  output logic [WIDTH-1:0]             data_out,
  output logic                         valid_out,
  input  logic                         ready_out,
  output logic [$clog2(DEPTH+1)-1:0]   count_1,
  output logic [$clog2(DEPTH+1)-1:0]   count_2
);
  logic [WIDTH-1:0]   w_head_1;
  logic [WIDTH-1:0]   w_head_2;
  logic [WIDTH-1:0]   w_sum;
  logic               w_adv;
  logic               w_fire;
  logic [WIDTH-1:0]   r_pipe_dat [LATENCY];
  logic [LATENCY-1:0] r_pipe_vld;

  pe_2in1out_join_fifo #(.W(WIDTH), .DEPTH(DEPTH)) u_fifo_1 (
    .clk        (clk),
    .rst        (rst),
    .i_push_vld (valid_in_1),
    .i_push_dat (data_in_1),
    .o_push_rdy (ready_in_1),
    .i_pop      (w_fire),
    .o_head_dat (w_head_1),
    .o_count    (count_1)
  );

  pe_2in1out_join_fifo #(.W(WIDTH), .DEPTH(DEPTH)) u_fifo_2 (
    .clk        (clk),
    .rst        (rst),
    .i_push_vld (valid_in_2),
    .i_push_dat (data_in_2),
    .o_push_rdy (ready_in_2),
    .i_pop      (w_fire),
    .o_head_dat (w_head_2),
    .o_count    (count_2)
  );

  // Global stall: any unaccepted output freezes every stage, bubbles included.
  assign w_adv  = !(r_pipe_vld[LATENCY-1] && !ready_out);
  assign w_fire = w_adv && (count_1 != '0) && (count_2 != '0);
  assign w_sum  = w_head_1 + w_head_2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LATENCY; i++) r_pipe_dat[i] <= '0;
      r_pipe_vld <= '0;
    end else if (w_adv) begin
      r_pipe_vld[0] <= w_fire;
      if (w_fire) r_pipe_dat[0] <= w_sum;
      for (int i = 1; i < LATENCY; i++) begin
        r_pipe_dat[i] <= r_pipe_dat[i-1];
        r_pipe_vld[i] <= r_pipe_vld[i-1];
      end
    end
  end

  assign data_out  = r_pipe_dat[LATENCY-1];
  assign valid_out = r_pipe_vld[LATENCY-1];
endmodule
